// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer_if
//  Brief    : Bundles the sample, coefficient-write and result handshakes of
//             fir_mac_sequencer. The master side feeds samples and
//             coefficients and consumes results; the slave side is the
//             filter.
//  Revision : 1.0  initial release
// ============================================================================
interface fir_mac_sequencer_if #(
    parameter int ORDER   = 32,
    parameter int WORD_IN = 8,
    parameter int COEF_W  = 10,
    parameter int ACC_W   = 24
);
    // Sample input handshake
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WORD_IN-1:0]   data_in;

    // Coefficient write port
    logic                        coef_wr_en;
    logic [$clog2(ORDER)-1:0]    coef_wr_addr;
    logic signed [COEF_W-1:0]    coef_wr_data;

    // Result output handshake
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_W-1:0]     data_out;

    // Status
    logic                        busy;

    modport master (
        output in_valid, data_in,
        output coef_wr_en, coef_wr_addr, coef_wr_data,
        output out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in,
        input  coef_wr_en, coef_wr_addr, coef_wr_data,
        input  out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_sequencer
//  Brief    : Time-multiplexed FIR filter. One signed multiplier is walked
//             over ORDER taps per accepted sample:
//                 y = sum_k c[k] * x[n-k],  k = 0..ORDER-1
//             Samples live in a circular buffer, coefficients in a register
//             file writable only while idle. Result is held until the
//             consumer takes it.
//  Config   : define FIR_SEQ_ALT_SIGN_EN to subtract odd taps instead of
//             adding them (highpass modulation of a lowpass table).
//  Revision : 1.0  initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int ORDER   = 32,
    parameter int WORD_IN = 8,
    parameter int COEF_W  = 10,
    parameter int ACC_W   = 24
) (
    input wire                   clk,
    input wire                   rst,
    fir_mac_sequencer_if.slave   bus
);

    localparam int              c_aw       = $clog2(ORDER);
    localparam int              c_prod_w   = WORD_IN + COEF_W;
    localparam logic [c_aw-1:0] c_last_tap = c_aw'(ORDER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;

    logic signed [WORD_IN-1:0]  r_samples [ORDER];
    logic signed [COEF_W-1:0]   r_coefs   [ORDER];
    logic [c_aw-1:0]            r_wr_ptr;
    logic [c_aw-1:0]            r_k;
    logic signed [ACC_W-1:0]    r_acc;

    logic                       w_in_ready;
    logic                       w_out_valid;
    logic                       w_busy;
    logic                       w_accept;
    logic                       w_coef_we;
    logic                       w_last_tap;
    logic [c_aw-1:0]            w_rd_idx;
    logic signed [c_prod_w-1:0] w_coef_x;
    logic signed [c_prod_w-1:0] w_samp_x;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_next;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
    // Coefficients are frozen for the duration of a pass; a write that
    // coincides with a sample accept lands before the first MAC cycle.
    assign w_coef_we  = (r_state == S_IDLE) && bus.coef_wr_en;
    assign w_last_tap = (r_k == c_last_tap);

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    // The write pointer was advanced on accept, so the newest sample sits
    // one slot behind it; tap k walks backwards through history.
    assign w_rd_idx = r_wr_ptr - 1'b1 - r_k;

    // Sign-extend both operands to the full product width so the product
    // is exact before it is extended into the accumulator.
    assign w_coef_x = c_prod_w'(r_coefs[r_k]);
    assign w_samp_x = c_prod_w'(r_samples[w_rd_idx]);
    assign w_prod   = w_coef_x * w_samp_x;

    generate
        if (ACC_W > c_prod_w) begin : g_prod_sext
            assign w_prod_ext = {{(ACC_W - c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
        end else begin : g_prod_trunc
            assign w_prod_ext = w_prod[ACC_W-1:0];
        end
    endgenerate

`ifdef FIR_SEQ_ALT_SIGN_EN
    // Odd taps subtract, even taps add; wraps modulo 2^ACC_W.
    assign w_acc_next = r_k[0] ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
`else
    // Every tap adds; wraps modulo 2^ACC_W.
    assign w_acc_next = r_acc + w_prod_ext;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = S_MAC;
                end
            end
            S_MAC: begin
                w_busy = 1'b1;
                if (w_last_tap) begin
                    w_next_state = S_OUT;
                end
            end
            S_OUT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage and accumulator
    // ------------------------------------------------------------------
    // Coefficient register file: cleared on reset, written only in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) begin
                r_coefs[i] <= '0;
            end
        end else if (w_coef_we) begin
            r_coefs[bus.coef_wr_addr] <= bus.coef_wr_data;
        end
    end

    // Sample ring buffer and write pointer: zeroed history so taps reaching
    // past the first post-reset sample contribute nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ORDER; i++) begin
                r_samples[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_accept) begin
            r_samples[r_wr_ptr] <= bus.data_in;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
        end
    end

    // Tap counter and accumulator: cleared on accept, one tap per MAC cycle.
    // The accumulator doubles as the result register held through OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k   <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_k   <= '0;
            r_acc <= '0;
        end else if (r_state == S_MAC) begin
            r_k   <= r_k + 1'b1;
            r_acc <= w_acc_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.data_out  = r_acc;

endmodule
`default_nettype wire
